// File: rtl/dmem_pkg.sv
// Shared definitions for the doubleword data-memory responder: access-size
// encoding, FSM state encoding, default geometry/latency and size helpers.
package dmem_pkg;

    // Access size as carried in funct3[1:0]
    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } size_e;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int DMEM_DEFAULT_DEPTH   = 32;
    localparam int DMEM_DEFAULT_LATENCY = 2;

    // Number of bytes touched by an access of the given size (1/2/4/8)
    function automatic logic [3:0] size_bytes(input size_e size);
        return 4'(4'd1 << size);
    endfunction

    // Low byte-offset bits that must be zero for a naturally aligned access
    function automatic logic [2:0] size_low_mask(input size_e size);
        return 3'((4'd1 << size) - 4'd1);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for one 64-bit doubleword: extracts and
// sign/zero-extends a load, and merges right-aligned store data into the
// addressed lanes while leaving the other lanes untouched.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [63:0] dword,
    input  logic [2:0]  offset,
    input  size_e       size,
    input  logic        is_unsigned,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic [63:0] merged
);

    logic [7:0]  lane_en;
    logic [63:0] wdata_shift;
    logic [63:0] rdata_shift;
    logic [3:0]  nbytes;

    assign nbytes      = size_bytes(size);
    assign wdata_shift = wdata << {offset, 3'b000};
    assign rdata_shift = dword >> {offset, 3'b000};

    // Per-lane enable and merge: lane gi is written when it lies inside [offset, offset+nbytes)
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign lane_en[gi] = (4'(gi) >= {1'b0, offset}) &&
                                 (4'(gi) < ({1'b0, offset} + nbytes));
            assign merged[gi*8 +: 8] = lane_en[gi] ? wdata_shift[gi*8 +: 8]
                                                   : dword[gi*8 +: 8];
        end
    endgenerate

    // Load extraction with sign or zero extension (doubleword ignores is_unsigned)
    always_comb begin
        rdata = rdata_shift;
        case (size)
            SIZE_B: rdata = is_unsigned ? {56'd0, rdata_shift[7:0]}
                                        : {{56{rdata_shift[7]}}, rdata_shift[7:0]};
            SIZE_H: rdata = is_unsigned ? {48'd0, rdata_shift[15:0]}
                                        : {{48{rdata_shift[15]}}, rdata_shift[15:0]};
            SIZE_W: rdata = is_unsigned ? {32'd0, rdata_shift[31:0]}
                                        : {{32{rdata_shift[31]}}, rdata_shift[31:0]};
            default: rdata = rdata_shift;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed response latency.
// A request is accepted in IDLE, held in WAIT until LATENCY cycles have
// elapsed, and presented in RESP until the requester takes it. Stores are
// committed on the edge entering RESP. Out-of-range accesses are rejected.
// Optional feature: define DMEM_RSP_ALIGN_CHECK_EN to reject misaligned
// accesses; otherwise the low address bits are forced to natural alignment.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = DMEM_DEFAULT_DEPTH,
    parameter int LATENCY = DMEM_DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    state_e             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               lat_write_reg;
    logic [63:0]        lat_addr_reg;
    logic [63:0]        lat_wdata_reg;
    logic [1:0]         lat_size_reg;
    logic               lat_unsigned_reg;

    logic [63:0]        mem [DEPTH];

    logic               accept;
    logic               enter_resp;
    logic               cur_write;
    logic [63:0]        cur_addr;
    logic [63:0]        cur_wdata;
    size_e              cur_size;
    logic               cur_unsigned;
    logic [IDX_W-1:0]   cur_idx;
    logic [2:0]         cur_off;
    logic               out_of_range;
    logic               misaligned;
    logic               acc_err;
    logic               commit;
    logic [63:0]        rd_dword;
    logic [63:0]        load_data;
    logic [63:0]        merged_dword;
    logic [63:0]        resp_data;

    assign accept = req_valid && req_ready;

    // In IDLE the live request is used (only matters when LATENCY==1); otherwise the latched one
    assign cur_write    = (state_reg == ST_IDLE) ? req_write    : lat_write_reg;
    assign cur_addr     = (state_reg == ST_IDLE) ? req_addr     : lat_addr_reg;
    assign cur_wdata    = (state_reg == ST_IDLE) ? req_wdata    : lat_wdata_reg;
    assign cur_size     = size_e'((state_reg == ST_IDLE) ? req_size : lat_size_reg);
    assign cur_unsigned = (state_reg == ST_IDLE) ? req_unsigned : lat_unsigned_reg;

    assign cur_idx      = cur_addr[3 +: IDX_W];
    assign cur_off      = cur_addr[2:0] & ~size_low_mask(cur_size);
    assign out_of_range = (cur_addr[63:3+IDX_W] != '0);

`ifdef DMEM_RSP_ALIGN_CHECK_EN
    assign misaligned = ((cur_addr[2:0] & size_low_mask(cur_size)) != 3'd0);
`else
    assign misaligned = 1'b0;
`endif

    assign acc_err = out_of_range || misaligned;

    assign enter_resp = ((state_reg == ST_IDLE) && accept && (LATENCY == 1)) ||
                        ((state_reg == ST_WAIT) && (cnt_reg == '0));

    assign commit    = enter_resp && cur_write && !acc_err && rst;
    assign rd_dword  = mem[cur_idx];
    assign resp_data = (cur_write || acc_err) ? 64'd0 : load_data;

    dmem_lane_align u_lane_align (
        .dword       (rd_dword),
        .offset      (cur_off),
        .size        (cur_size),
        .is_unsigned (cur_unsigned),
        .wdata       (cur_wdata),
        .rdata       (load_data),
        .merged      (merged_dword)
    );

    // Storage array: written only on the commit edge, never cleared
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[cur_idx] <= merged_dword;
        end
    end

    // Request/response FSM with registered handshake and response outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= '0;
            req_ready        <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_rdata        <= 64'd0;
            rsp_err          <= 1'b0;
            lat_write_reg    <= 1'b0;
            lat_addr_reg     <= 64'd0;
            lat_wdata_reg    <= 64'd0;
            lat_size_reg     <= 2'd0;
            lat_unsigned_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        lat_write_reg    <= req_write;
                        lat_addr_reg     <= req_addr;
                        lat_wdata_reg    <= req_wdata;
                        lat_size_reg     <= req_size;
                        lat_unsigned_reg <= req_unsigned;
                        req_ready        <= 1'b0;
                        if (LATENCY == 1) begin
                            state_reg <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= resp_data;
                            rsp_err   <= acc_err;
                        end else begin
                            state_reg <= ST_WAIT;
                            cnt_reg   <= CNT_W'(LATENCY - 2);
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= resp_data;
                        rsp_err   <= acc_err;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_reg <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 64'd0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (DEPTH=32, LATENCY=2). A byte-array
// reference model predicts every response; directed scenarios are followed
// by a randomized run. Honours DMEM_RSP_ALIGN_CHECK_EN like the design.
module tb_dmem_responder;

    localparam int DEPTH   = 32;
    localparam int LATENCY = 2;
    localparam int BYTES   = DEPTH * 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] ref_mem [BYTES];

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: byte-addressed memory, natural-size accesses
    function automatic void model(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                                  input logic [1:0] sz, input logic uns,
                                  output logic [63:0] rd, output logic er);
        int nb;
        int base;
        nb = 1 << sz;
        er = (addr >= 64'(BYTES));
`ifdef DMEM_RSP_ALIGN_CHECK_EN
        if ((addr % 64'(nb)) != 0) er = 1'b1;
`endif
        rd = 64'd0;
        if (!er) begin
            base = (int'(addr) / nb) * nb;
            if (wr) begin
                for (int i = 0; i < nb; i++) ref_mem[base + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) rd[8*i +: 8] = ref_mem[base + i];
                if (!uns && nb < 8 && rd[8*nb - 1]) begin
                    for (int i = nb; i < 8; i++) rd[8*i +: 8] = 8'hFF;
                end
            end
        end
    endfunction

    // One complete transaction: accept, latency check, optional stall, handshake
    task automatic transact(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                            input logic [1:0] sz, input logic uns, input int hold,
                            output logic [63:0] rd, output logic er);
        logic [63:0] exp_rd;
        logic        exp_er;
        int n;
        model(wr, addr, wd, sz, uns, exp_rd, exp_er);
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        check("req_ready_before_accept", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        req_size = sz; req_unsigned = uns;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        check("rsp_latency", 64'(n), 64'(LATENCY));
        rd = rsp_rdata;
        er = rsp_err;
        $display("txn wr=%0d addr=%h size=%0d uns=%0d wdata=%h -> rdata=%h err=%0d",
                 wr, addr, sz, uns, wd, rd, er);
        check("rsp_rdata", rd, exp_rd);
        check("rsp_err", 64'(er), 64'(exp_er));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
            check("stall_rsp_rdata", rsp_rdata, rd);
            check("stall_req_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("post_hs_rsp_valid", 64'(rsp_valid), 64'd0);
        check("post_hs_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        check("next_cycle_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
    endtask

    logic [63:0] rd;
    logic        er;
    logic [63:0] val;

    initial begin
        // Reset state
        #12;
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_rdata", rsp_rdata, 64'd0);
        check("reset_rsp_err", 64'(rsp_err), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("first_edge_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);

        // Fill every doubleword with known random data
        for (int i = 0; i < DEPTH; i++) begin
            val = {$urandom, $urandom};
            transact(1'b1, 64'(i * 8), val, 2'd3, 1'b0, 0, rd, er);
        end

        // Store then load doubleword
        transact(1'b1, 64'h10, 64'h1122334455667788, 2'd3, 1'b0, 0, rd, er);
        transact(1'b0, 64'h10, 64'd0, 2'd3, 1'b0, 0, rd, er);
        check("dword_readback", rd, 64'h1122334455667788);

        // Byte store with signed/unsigned loads
        transact(1'b1, 64'h13, 64'h80, 2'd0, 1'b0, 0, rd, er);
        transact(1'b0, 64'h13, 64'd0, 2'd0, 1'b0, 0, rd, er);
        check("lb_signed", rd, 64'hFFFFFFFFFFFFFF80);
        transact(1'b0, 64'h13, 64'd0, 2'd0, 1'b1, 0, rd, er);
        check("lbu_unsigned", rd, 64'h80);
        transact(1'b0, 64'h10, 64'd0, 2'd3, 1'b0, 0, rd, er);
        check("byte_merge", rd, 64'h1122334480667788);

        // Out-of-range load and store
        transact(1'b0, 64'h100, 64'd0, 2'd3, 1'b0, 0, rd, er);
        check("oor_load_err", 64'(er), 64'd1);
        check("oor_load_rdata", rd, 64'd0);
        transact(1'b1, 64'h100, 64'hDEADBEEFDEADBEEF, 2'd3, 1'b0, 0, rd, er);
        check("oor_store_err", 64'(er), 64'd1);
        for (int i = 0; i < DEPTH; i++) begin
            transact(1'b0, 64'(i * 8), 64'd0, 2'd3, 1'b0, 0, rd, er);
        end

        // Response stall of five cycles
        transact(1'b0, 64'h10, 64'd0, 2'd3, 1'b0, 5, rd, er);

        // Misaligned word store at 0x12
        transact(1'b1, 64'h12, 64'hCAFEF00D, 2'd2, 1'b0, 0, rd, er);
`ifdef DMEM_RSP_ALIGN_CHECK_EN
        check("misaligned_err", 64'(er), 64'd1);
        transact(1'b0, 64'h10, 64'd0, 2'd3, 1'b0, 0, rd, er);
        check("misaligned_no_write", rd, 64'h1122334480667788);
`else
        check("misaligned_no_err", 64'(er), 64'd0);
        transact(1'b0, 64'h10, 64'd0, 2'd3, 1'b0, 0, rd, er);
        check("misaligned_forced", rd, 64'h11223344CAFEF00D);
`endif

        // Reset during WAIT of a store: dropped, no write
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20;
        req_wdata = 64'h0123456789ABCDEF; req_size = 2'd3; req_unsigned = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        req_valid = 1'b0;
        #1;
        check("rst_wait_req_ready", 64'(req_ready), 64'd0);
        check("rst_wait_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_wait_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_wait_rsp_err", 64'(rsp_err), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_release_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        transact(1'b0, 64'h20, 64'd0, 2'd3, 1'b0, 0, rd, er);

        // Randomized mix against the reference model
        for (int i = 0; i < 80; i++) begin
            transact(1'($urandom_range(0, 1)), 64'($urandom_range(0, BYTES + 31)),
                     {$urandom, $urandom}, 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), rd, er);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
